toggle_memory: RTL and testbench
================================

// Module: toggle_memory
// PURPOSE
// - Per-ID single-bit toggle store (LUTRAM style) for tracking in-flight instruction status.
// - Each event source owns one instance and flips the bit of the ID it completes or issues.
// - The ID-management logic XORs the read_data of several instances to get "ID in use" per ID.
// - Write port: one toggle per cycle. Read port: one combinational read.
// PARAMETERS
// - DEPTH  default 8 (MAX_IDS)  number of tracked IDs; power of two, >= 2
// - ID_W   default $clog2(DEPTH)  ID index width (derived, not overridden)
// PORTS
// - clk        in   1     single clock, all state on rising edge
// - rst        in   1     reset, asynchronous, active-low (0 = reset)
// - toggle     in   1     flip the bit at toggle_id this cycle
// - toggle_id  in   ID_W  entry to flip
// - read_id    in   ID_W  entry to read
// - read_data  out  1     current bit of entry read_id
// BEHAVIOUR
// - Storage: DEPTH x 1-bit array mem[], no other state.
// - Reset: rst low clears every mem[] entry to 0 immediately, independent of clk;
//   read_data = 0 for any read_id while rst is low; toggle is ignored during reset.
// - First edge after rst deasserts may toggle normally.
// - Write: at posedge clk with rst high and toggle=1: mem[toggle_id] <= ~mem[toggle_id].
//   toggle=0: no entry changes. Exactly one entry changes per toggle; others hold.
// - Read: read_data = mem[read_id], purely combinational (zero latency, no register).
// - Same-cycle toggle and read of the same ID: read_data shows the pre-toggle value;
//   new value visible from the cycle after the edge (default, without bypass).
// - Toggling the same ID on N consecutive cycles: bit ends at initial ^ (N mod 2).
// - toggle_id/read_id always in range (power-of-two DEPTH); no wrap logic required.
// - Toggle with X on toggle_id is a usage error; simulation assertion flags toggle=1
//   with unknown toggle_id.
// - Composition rule (user side): an ID is free when the XOR of all paired
//   issue/complete instances is 0; this block stores only its own parity.
// CONFIGURATION
// - TOGGLE_MEMORY_BYPASS_EN defined: read_data =
//   mem[read_id] ^ (toggle & rst & (toggle_id == read_id)), i.e. same-cycle
//   toggle is forwarded to the read port (zero-latency visibility).
// - Not defined (default): no forwarding; read_data = mem[read_id] only; behaviour
//   as stated above. Bypass adds a comparator on the read path; default build is
//   required by ID management (read is used one cycle ahead and registered).
// TESTING
// - Reset: hold rst=0, sweep read_id 0..7 -> read_data=0 for all; assert rst=0
//   asynchronously mid-cycle after toggling IDs 2,5 -> all reads 0 immediately.
// - Single toggle: toggle=1,toggle_id=3 for one cycle -> read_id=3 gives 1 next cycle,
//   IDs 0-2,4-7 still 0.
// - Double toggle: toggle ID 6 on two consecutive cycles -> read_id=6 returns 1 then 0.
// - Same-cycle read: toggle ID 4 with read_id=4 -> read_data=0 in that cycle,
//   1 after edge (default); with TOGGLE_MEMORY_BYPASS_EN -> 1 in that cycle.
// - Random: 1000 cycles random toggle/toggle_id/read_id vs. 8-bit parity model ->
//   read_data matches model every cycle; toggle=0 cycles change nothing.
// - Pairing: two instances, "issue" toggles ID 1, "complete" toggles ID 1 later ->
//   XOR of reads for ID 1 goes 0 -> 1 -> 0.

Source files
------------

// File: rtl/toggle_memory.sv
// toggle_memory: DEPTH x 1-bit per-ID toggle store with a combinational read port.
// Define TOGGLE_MEMORY_BYPASS_EN to forward a same-cycle toggle onto the read port.
module toggle_memory #(
  parameter  int DEPTH = 8,
  localparam int ID_W  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            toggle,
  input  logic [ID_W-1:0] toggle_id,
  input  logic [ID_W-1:0] read_id,
  output logic            read_data
);

  logic [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0] mem_d;
  logic             fwd_s;

  // Next-state: flip exactly the addressed entry when toggle is set.
  always_comb begin
    mem_d = mem_q;
    if (toggle) begin
      mem_d[toggle_id] = ~mem_q[toggle_id];
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage; reset clears every entry immediately, independent of clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= {DEPTH{1'b0}};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Forwarding term: only meaningful in the bypass build.
  always_comb begin
    fwd_s = 1'b0;
`ifdef TOGGLE_MEMORY_BYPASS_EN
    if (toggle && rst && (toggle_id == read_id)) begin
      fwd_s = 1'b1;
    end else begin
      fwd_s = 1'b0;
    end
`else
    fwd_s = 1'b0;
`endif
  end

  // Zero-latency read; forced low while reset is held.
  always_comb begin
    read_data = 1'b0;
    if (rst) begin
      read_data = mem_q[read_id] ^ fwd_s;
    end else begin
      read_data = 1'b0;
    end
  end

  toggle_memory_chk #(.ID_W(ID_W)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .toggle    (toggle),
    .toggle_id (toggle_id)
  );

endmodule

// Usage checker: a toggle must always name a known entry.
module toggle_memory_chk #(
  parameter int ID_W = 3
) (
  input logic            clk,
  input logic            rst,
  input logic            toggle,
  input logic [ID_W-1:0] toggle_id
);

  a_toggle_id_known: assert property (
    @(posedge clk) disable iff (!rst) toggle |-> !$isunknown(toggle_id)
  );

endmodule

// File: tb/tb_toggle_memory.sv
// Scoreboard bench for toggle_memory: two instances (issue/complete) checked against
// a per-ID parity array model; a monitor pops expected reads each cycle.
module tb_toggle_memory;

  localparam int DEPTH = 8;
  localparam int ID_W  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            tog_a = 1'b0, tog_b = 1'b0;
  logic [ID_W-1:0] tid_a = '0, tid_b = '0, rid = '0;
  logic            rd_a, rd_b;

  always #5 clk = ~clk;

  toggle_memory #(.DEPTH(DEPTH)) u_iss (
    .clk(clk), .rst(rst), .toggle(tog_a), .toggle_id(tid_a),
    .read_id(rid), .read_data(rd_a)
  );

  toggle_memory #(.DEPTH(DEPTH)) u_cmp (
    .clk(clk), .rst(rst), .toggle(tog_b), .toggle_id(tid_b),
    .read_id(rid), .read_data(rd_b)
  );

  typedef struct {
    bit    exp_a;
    bit    exp_x;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  bit   model_a[DEPTH];
  bit   model_b[DEPTH];
  int   errors = 0;
  int   checks = 0;
  bit   chk_v  = 1'b0;

  // Expected read: stored parity, plus the in-flight toggle when forwarding is built in.
  function automatic bit exp_read(input bit stored, input bit r_n, input bit tg,
                                  input int tid, input int r);
    bit fwd;
    fwd = 1'b0;
`ifdef TOGGLE_MEMORY_BYPASS_EN
    fwd = tg && (tid == r);
`endif
    return r_n ? (stored ^ fwd) : 1'b0;
  endfunction

  task automatic drive(input bit r_n, input bit ta, input int ia,
                       input bit tb, input int ib, input int r, input string tag);
    exp_t e;
    bit   ea, eb;
    @(negedge clk);
    rst   = r_n;
    tog_a = ta;  tid_a = ID_W'(ia);
    tog_b = tb;  tid_b = ID_W'(ib);
    rid   = ID_W'(r);
    ea = exp_read(model_a[r], r_n, ta, ia, r);
    eb = exp_read(model_b[r], r_n, tb, ib, r);
    e.exp_a = ea;
    e.exp_x = ea ^ eb;
    e.tag   = tag;
    sb_q.push_back(e);
    chk_v = 1'b1;
    if (r_n && ta) model_a[ia] = ~model_a[ia];
    if (r_n && tb) model_b[ib] = ~model_b[ib];
  endtask

  // Drop reset in the middle of a low clock phase, away from any edge.
  task automatic async_reset(input int r, input string tag);
    exp_t e;
    @(negedge clk);
    tog_a = 1'b0;
    tog_b = 1'b0;
    rid   = ID_W'(r);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      model_a[i] = 1'b0;
      model_b[i] = 1'b0;
    end
    e.exp_a = 1'b0;
    e.exp_x = 1'b0;
    e.tag   = tag;
    sb_q.push_back(e);
    chk_v = 1'b1;
  endtask

  // Monitor: samples mid low-phase and compares against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (chk_v) begin
        chk_v = 1'b0;
        if (sb_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL sb_empty: DUT presented a read with no expectation queued");
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (rd_a !== e.exp_a) begin
            errors++;
            $display("FAIL %s read_data: id=%0d got=%b want=%b", e.tag, rid, rd_a, e.exp_a);
          end
          checks++;
          if ((rd_a ^ rd_b) !== e.exp_x) begin
            errors++;
            $display("FAIL %s pair_xor: id=%0d got=%b want=%b", e.tag, rid, rd_a ^ rd_b, e.exp_x);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_a[i] = 1'b0;
      model_b[i] = 1'b0;
    end

    // Reset held: toggles ignored, every read is 0.
    for (int r = 0; r < DEPTH; r++)
      drive(1'b0, 1'b1, $urandom_range(DEPTH-1), 1'b1, $urandom_range(DEPTH-1), r, "rst_sweep");

    // First edge after release toggles ID 3; then sweep all IDs.
    drive(1'b1, 1'b1, 3, 1'b0, 0, 0, "single");
    for (int r = 0; r < DEPTH; r++)
      drive(1'b1, 1'b0, 0, 1'b0, 0, r, "single_rd");

    // Double toggle on ID 6.
    drive(1'b1, 1'b1, 6, 1'b0, 0, 6, "dbl_0");
    drive(1'b1, 1'b1, 6, 1'b0, 0, 6, "dbl_1");
    drive(1'b1, 1'b0, 0, 1'b0, 0, 6, "dbl_2");

    // Same-cycle toggle and read of ID 4.
    drive(1'b1, 1'b1, 4, 1'b0, 0, 4, "same_cyc");
    drive(1'b1, 1'b0, 0, 1'b0, 0, 4, "same_after");

    // Toggle IDs 2 and 5, then reset asynchronously mid-cycle.
    drive(1'b1, 1'b1, 2, 1'b1, 5, 2, "pre_rst_2");
    drive(1'b1, 1'b1, 5, 1'b0, 0, 5, "pre_rst_5");
    async_reset(2, "async_rst");
    for (int r = 0; r < DEPTH; r++)
      drive(1'b0, 1'b0, 0, 1'b0, 0, r, "async_sweep");

    // Pairing: issue toggles ID 1, complete toggles ID 1 later.
    drive(1'b1, 1'b1, 1, 1'b0, 0, 1, "pair_issue");
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1, "pair_busy");
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1, "pair_busy");
    drive(1'b1, 1'b0, 0, 1'b1, 1, 1, "pair_cmpl");
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1, "pair_free");

    // Random traffic on both instances.
    for (int n = 0; n < 1000; n++)
      drive(1'b1, 1'($urandom_range(1)), $urandom_range(DEPTH-1),
            1'($urandom_range(1)), $urandom_range(DEPTH-1),
            $urandom_range(DEPTH-1), "random");

    @(negedge clk);
    tog_a = 1'b0;
    tog_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got=%0d entries left want=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
